// File: rtl/pattern_detector_pkg.sv
// pattern_detector_pkg: shared state encodings and config helpers for pattern_detector
package pattern_detector_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ARMED = 2'd2,
    ST_MATCH = 2'd3
  } state_e;
  // Out-of-range pattern lengths fall back to the full register width
  function automatic int clamp_len(input int len, input int pat_w);
    return (len == 0 || len > pat_w) ? pat_w : len;
  endfunction
endpackage

// File: rtl/pd_match_counter.sv
// pd_match_counter: saturating match counter with synchronous clear
// Ports: clk, rst_n (async active-low), clr_i (clear, wins over inc_i),
//        inc_i (count one match), cnt_o (count), sat_o (count is all ones)
module pd_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);
  logic [CNT_W-1:0] cnt_d;
  always_comb begin
    cnt_d = clr_i ? '0 : (inc_i && !sat_o) ? cnt_o + CNT_W'(1) : cnt_o;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_o <= '0;
    else        cnt_o <= cnt_d;
  end
  assign sat_o = &cnt_o;
endmodule

// File: rtl/pattern_detector.sv
// pattern_detector: programmable serial bit-pattern detector with saturating match count
// Ports: clk, rst (async active-low), din/din_valid (serial stream),
//        cfg_load/cfg_pattern/cfg_len/cfg_overlap (run-time config), cnt_clr (clear count),
//        dout (registered one-cycle match pulse), match_cnt (saturating count), cnt_sat
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter int               PAT_W       = 4,
  parameter logic [PAT_W-1:0] RST_PATTERN = 4'b1010,
  parameter bit               RST_OVERLAP = 1'b1,
  parameter int               CNT_W       = 8,
  localparam int              LW          = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LW-1:0]    cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);
  state_e           current_state, state_d;
  // The oldest history bit only ever matters together with the incoming bit, so it is not stored
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [PAT_W-1:0] pattern_q, pattern_d, hist_s, mask;
  logic [LW-1:0]    fill_q, fill_d, fill_s, len_q, len_d;
  logic             overlap_q, overlap_d, hit;
  always_comb begin
    hist_s    = {hist_q, din};
    fill_s    = (fill_q == LW'(PAT_W)) ? fill_q : fill_q + LW'(1);
    // len_q == PAT_W shifts every one out, leaving a full mask
    mask      = ~({PAT_W{1'b1}} << len_q);
    hit       = din_valid && !cfg_load && fill_s >= len_q && ((hist_s ^ pattern_q) & mask) == '0;
    hist_d    = cfg_load ? '0 : din_valid ? hist_s[PAT_W-2:0] : hist_q;
    fill_d    = cfg_load ? '0 : !din_valid ? fill_q : (hit && !overlap_q) ? '0 : fill_s;
    pattern_d = cfg_load ? cfg_pattern : pattern_q;
    len_d     = cfg_load ? LW'(clamp_len(int'(cfg_len), PAT_W)) : len_q;
    overlap_d = cfg_load ? cfg_overlap : overlap_q;
    state_d   = hit ? ST_MATCH : (fill_d == '0) ? ST_IDLE : (fill_d < len_d) ? ST_FILL : ST_ARMED;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q        <= '0;
      fill_q        <= '0;
      pattern_q     <= RST_PATTERN;
      len_q         <= LW'(PAT_W);
      overlap_q     <= RST_OVERLAP;
      current_state <= ST_IDLE;
    end else begin
      hist_q        <= hist_d;
      fill_q        <= fill_d;
      pattern_q     <= pattern_d;
      len_q         <= len_d;
      overlap_q     <= overlap_d;
      current_state <= state_d;
    end
  end
  assign dout = current_state == ST_MATCH;
  pd_match_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (cnt_clr),
    .inc_i (hit),
    .cnt_o (match_cnt),
    .sat_o (cnt_sat)
  );
endmodule

// File: tb/tb_pattern_detector.sv
// tb_pattern_detector: queue-based reference model plus directed literal checks for pattern_detector
module tb_pattern_detector;
  import pattern_detector_pkg::*;
  localparam int PAT_W = 4;
  logic       clk = 0, rst, din, din_valid, cfg_load, cfg_overlap, cnt_clr;
  logic [3:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic       dout, cnt_sat, dout2, cnt_sat2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  pattern_detector dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .dout(dout), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );
  pattern_detector #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .dout(dout2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  // Reference model: the valid bits received since reset/config/non-overlapping match
  bit         mq[$];
  logic [3:0] m_pat = 4'b1010;
  int         m_len = PAT_W;
  bit         m_ov = 1, m_hit, m_ok;
  int         e_dout = 0, e_cnt = 0, e_cnt2 = 0, e_state = 0;

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_pat = 4'b1010; m_len = PAT_W; m_ov = 1;
      e_dout = 0; e_cnt = 0; e_cnt2 = 0; e_state = int'(ST_IDLE);
    end else begin
      m_hit = 0;
      if (cfg_load) begin
        m_pat = cfg_pattern;
        m_len = (cfg_len == 0 || cfg_len > PAT_W) ? PAT_W : int'(cfg_len);
        m_ov  = cfg_overlap;
        mq.delete();
      end else if (din_valid) begin
        mq.push_back(din);
        if (mq.size() > PAT_W) void'(mq.pop_front());
        if (mq.size() >= m_len) begin
          m_ok = 1;
          for (int i = 0; i < m_len; i++) if (mq[mq.size()-1-i] != m_pat[i]) m_ok = 0;
          m_hit = m_ok;
        end
        if (m_hit && !m_ov) mq.delete();
      end
      e_dout  = m_hit;
      e_cnt   = cnt_clr ? 0 : (m_hit && e_cnt < 255) ? e_cnt + 1 : e_cnt;
      e_cnt2  = cnt_clr ? 0 : (m_hit && e_cnt2 < 3) ? e_cnt2 + 1 : e_cnt2;
      e_state = m_hit ? int'(ST_MATCH) : mq.size() == 0 ? int'(ST_IDLE) :
                mq.size() < m_len ? int'(ST_FILL) : int'(ST_ARMED);
    end
  end

  always @(negedge clk) begin
    chk("dout", dout, e_dout);
    chk("match_cnt", match_cnt, e_cnt);
    chk("cnt_sat", cnt_sat, e_cnt == 255);
    chk("dout2", dout2, e_dout);
    chk("match_cnt2", match_cnt2, e_cnt2);
    chk("cnt_sat2", cnt_sat2, e_cnt2 == 3);
    chk("state", dut.current_state, e_state);
  end

  task automatic tick(input bit d, v, ld, clr);
    @(negedge clk); #1;
    din = d; din_valid = v; cfg_load = ld; cnt_clr = clr;
  endtask

  task automatic tc(input bit d, v, ld, clr, input int ed, ec, ec2);
    tick(d, v, ld, clr);
    @(posedge clk); #1;
    chk("pin_dout", dout, ed);
    chk("pin_cnt", match_cnt, ec);
    chk("pin_cnt2", match_cnt2, ec2);
    chk("pin_sat2", cnt_sat2, ec2 == 3);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 0; din_valid = 0; cfg_load = 0; cnt_clr = 0;
    @(negedge clk); #1;
    rst = 1;
  endtask

  initial begin
    rst = 0; din = 0; din_valid = 0; cfg_load = 0; cnt_clr = 0;
    cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
    repeat (2) @(negedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    chk("rst_dout", dout, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_sat", cnt_sat, 0);
    // Default "1010" overlapping: pulses after bits 4 and 6
    tc(1, 1, 0, 0, 0, 0, 0); tc(0, 1, 0, 0, 0, 0, 0);
    tc(1, 1, 0, 0, 0, 0, 0); tc(0, 1, 0, 0, 1, 1, 1);
    tc(1, 1, 0, 0, 0, 1, 1); tc(0, 1, 0, 0, 1, 2, 2);
    // Load "11" non-overlapping; the valid bit on the load edge is dropped
    cfg_pattern = 4'b0011; cfg_len = 3'd2; cfg_overlap = 0;
    tc(1, 1, 1, 0, 0, 2, 2);
    tc(1, 1, 0, 0, 0, 2, 2); tc(1, 1, 0, 0, 1, 3, 3);
    tc(1, 1, 0, 0, 0, 3, 3); tc(1, 1, 0, 0, 1, 4, 3);
    // Stall in the middle of a pattern
    do_reset();
    tc(1, 1, 0, 0, 0, 0, 0); tc(0, 1, 0, 0, 0, 0, 0);
    tc(1, 0, 0, 0, 0, 0, 0); tc(1, 0, 0, 0, 0, 0, 0); tc(1, 0, 0, 0, 0, 0, 0);
    tc(1, 1, 0, 0, 0, 0, 0); tc(0, 1, 0, 0, 1, 1, 1);
    // Reset mid-pattern discards the partial history
    do_reset();
    tc(1, 1, 0, 0, 0, 0, 0); tc(0, 1, 0, 0, 0, 0, 0); tc(1, 1, 0, 0, 0, 0, 0);
    do_reset();
    tc(0, 1, 0, 0, 0, 0, 0);
    tc(1, 1, 0, 0, 0, 0, 0); tc(0, 1, 0, 0, 0, 0, 0);
    tc(1, 1, 0, 0, 0, 0, 0); tc(0, 1, 0, 0, 1, 1, 1);
    // Saturation of the 2-bit counter, then clear coincident with the 6th match
    do_reset();
    cfg_pattern = 4'b0011; cfg_len = 3'd2; cfg_overlap = 0;
    tc(0, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 12; k++)
      tc(1, 1, 0, k == 12, k % 2 == 0, k == 12 ? 0 : k / 2, k == 12 ? 0 : (k / 2 > 3 ? 3 : k / 2));
    // Random stream against the model
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk); #1;
      rst         = $urandom_range(0, 2999) != 0;
      din         = 1'($urandom_range(0, 1));
      din_valid   = $urandom_range(0, 3) != 0;
      cfg_load    = $urandom_range(0, 149) == 0;
      cnt_clr     = $urandom_range(0, 199) == 0;
      cfg_pattern = 4'($urandom_range(0, 15));
      cfg_len     = 3'($urandom_range(0, 7));
      cfg_overlap = 1'($urandom_range(0, 1));
    end
    tick(0, 0, 0, 0);
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
